// File: rtl/mac_pkg.sv
// Shared constants and helpers for the MAC datapath blocks.
// Latency: none (package only).
// Backpressure: not applicable.
package mac_pkg;

    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] SAT_POS = 8'h7F;
    localparam logic [DATA_W-1:0] SAT_NEG = 8'h80;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int id_width(input int num_req);
        int w;
        w = $clog2(num_req);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/adder8.sv
// Plain 8-bit two's-complement adder, wrap-around result.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module adder8
    import mac_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/sat_add_arbiter.sv
// Round-robin share of one saturating 8-bit adder among NUM_REQ requesters.
// Latency: one cycle from accept to resp_valid; one result per cycle.
// Backpressure: a held result (resp_valid & !resp_ready) blocks all req_ready.
module sat_add_arbiter
    import mac_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int CNT_W   = 16,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_W-1:0]         resp_sum,
    output logic [ID_W-1:0]           resp_id,
    output logic                      resp_ovf,
    output logic [CNT_W-1:0]          ovf_count,
    input  logic                      ovf_clr
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               out_free;
    logic               xfer;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic [DATA_W-1:0]  raw_sum;
    logic               sum_ovf;
    logic [DATA_W-1:0]  sat_sum;

    // Output register can take a new result when empty or draining this cycle.
    assign out_free = !resp_valid || resp_ready;

    // First valid requester at or above rr_ptr, wrapping past the last index.
    always_comb begin
        int  idx;
        logic found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
                found      = 1'b1;
            end
        end
    end

    // Nothing is offered while reset is held, so no transfer can be lost.
    assign req_ready = rst ? '0 : (grant & {NUM_REQ{out_free}});
    assign xfer      = |req_ready;

    // AND-OR operand mux steered by the one-hot grant.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a = op_a | (req_a[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
            op_b = op_b | (req_b[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
        end
    end

    adder8 u_adder8 (
        .a   (op_a),
        .b   (op_b),
        .sum (raw_sum)
    );

    // Signed overflow: like-signed operands produce a sum of the other sign.
    assign sum_ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                     (raw_sum[DATA_W-1] != op_a[DATA_W-1]);
    assign sat_sum = sum_ovf ? (op_a[DATA_W-1] ? SAT_NEG : SAT_POS) : raw_sum;

    // Result register: load on transfer, otherwise empty out when drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_sum   <= '0;
            resp_id    <= '0;
            resp_ovf   <= 1'b0;
        end else if (xfer) begin
            resp_valid <= 1'b1;
            resp_sum   <= sat_sum;
            resp_id    <= grant_id;
            resp_ovf   <= sum_ovf;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    // Round-robin pointer moves just past the winner; holds when idle or stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        end
    end

    // Saturating clamp-event counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (ovf_clr) begin
            ovf_count <= '0;
        end else if (xfer && sum_ovf && (ovf_count != '1)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule
